// File: rtl/pcie_cfg_arb.sv
// pcie_cfg_arb: two-requester configuration-request arbiter in front of a PCIe
// configuration transactor. A granted request's TLP fields are latched onto cfg_*,
// launched with a 2-cycle tx_en level, and completed by cpl_rcv or by a timeout.
// The result is returned on a one-cycle reqN_done pulse. A 3-cycle quiet gap follows
// every completion so that the transactor's edge detector can re-arm.
// Optional build macro: CFG_CRS_RETRY_EN. When it is defined, a CRS completion
// reissues the request with a new tag, up to MAX_RETRY times.
// Ports:
//   pclk_div2, apb_rst                  clock; asynchronous active-high reset
//   reqN_valid/wr/type/fbe/des_id/      request N (N=0,1); valid is held until done
//   reqN_reg_num/wdata
//   reqN_done/status/rdata/timeout      result for request N, valid while done is high
//   cfg_fmt/type/tag/fbe/des_id/        TLP fields to the transactor
//   cfg_reg_num/tx_data
//   tx_en                               launch level to the transactor
//   cpl_rcv/cpl_status/cpl_rx_data      completion from the transactor
module pcie_cfg_arb #(
   parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
   parameter logic [7:0]  TAG_BASE    = 8'h10,
   parameter logic [3:0]  MAX_RETRY   = 4'd8
) (
   input  logic        pclk_div2,
   input  logic        apb_rst,
   input  logic        req0_valid,
   input  logic        req0_wr,
   input  logic        req0_type,
   input  logic [3:0]  req0_fbe,
   input  logic [15:0] req0_des_id,
   input  logic [9:0]  req0_reg_num,
   input  logic [31:0] req0_wdata,
   output logic        req0_done,
   output logic [2:0]  req0_status,
   output logic [31:0] req0_rdata,
   output logic        req0_timeout,
   input  logic        req1_valid,
   input  logic        req1_wr,
   input  logic        req1_type,
   input  logic [3:0]  req1_fbe,
   input  logic [15:0] req1_des_id,
   input  logic [9:0]  req1_reg_num,
   input  logic [31:0] req1_wdata,
   output logic        req1_done,
   output logic [2:0]  req1_status,
   output logic [31:0] req1_rdata,
   output logic        req1_timeout,
   output logic        cfg_fmt,
   output logic        cfg_type,
   output logic [7:0]  cfg_tag,
   output logic [3:0]  cfg_fbe,
   output logic [15:0] cfg_des_id,
   output logic [9:0]  cfg_reg_num,
   output logic [31:0] cfg_tx_data,
   output logic        tx_en,
   input  logic        cpl_rcv,
   input  logic [2:0]  cpl_status,
   input  logic [31:0] cpl_rx_data
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, GAP} state_t;

   // ISSUE and GAP both last three cycles (count 0..2)
   localparam logic [15:0] PHASE_LAST = 16'd2;

   state_t      r_state, w_state_nxt;
   logic [15:0] r_cnt, w_cnt_nxt;
   logic        r_tx_en, w_tx_en_nxt;
   logic        r_gnt, r_rr_last, w_gnt_id;
   logic        w_grant, w_issue, w_cap, w_timeout;
   logic [2:0]  w_status;
   logic [31:0] w_rdata;
   logic        w_crs_retry, w_retry_pend;
   logic [7:0]  r_next_tag, r_cfg_tag;
   logic        r_cfg_fmt, r_cfg_type;
   logic [3:0]  r_cfg_fbe;
   logic [15:0] r_cfg_des_id;
   logic [9:0]  r_cfg_reg_num;
   logic [31:0] r_cfg_tx_data;
   logic        r_done0, r_done1, r_timeout0, r_timeout1;
   logic [2:0]  r_status0, r_status1;
   logic [31:0] r_rdata0, r_rdata1;

   // Round-robin: on contention the loser of the previous contended grant wins
   assign w_gnt_id = (req0_valid && req1_valid) ? ~r_rr_last : req1_valid;

`ifdef CFG_CRS_RETRY_EN
   localparam logic [2:0] CRS_STATUS = 3'b010;
   logic [3:0] r_retry_cnt;
   logic       r_retry_pend;
   logic       w_retry;

   assign w_crs_retry  = (cpl_status == CRS_STATUS) && (r_retry_cnt < MAX_RETRY);
   assign w_retry      = (r_state == WAIT) && cpl_rcv && w_crs_retry;
   assign w_retry_pend = r_retry_pend;

   // CRS retry bookkeeping; the count restarts with every new grant
   always_ff @(posedge pclk_div2 or posedge apb_rst) begin
      if (apb_rst) begin
         r_retry_cnt  <= 4'd0;
         r_retry_pend <= 1'b0;
      end else begin
         if (w_grant)      r_retry_cnt <= 4'd0;
         else if (w_retry) r_retry_cnt <= r_retry_cnt + 4'd1;
         if (w_retry)      r_retry_pend <= 1'b1;
         else if (w_issue) r_retry_pend <= 1'b0;
      end
   end
`else
   assign w_crs_retry  = 1'b0;
   assign w_retry_pend = 1'b0;
`endif

   // Next-state and registered-output decode
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 16'd1;
      w_tx_en_nxt = 1'b0;
      w_grant     = 1'b0;
      w_issue     = 1'b0;
      w_cap       = 1'b0;
      w_timeout   = 1'b0;
      w_status    = 3'b000;
      w_rdata     = 32'd0;
      case (r_state)
         IDLE: begin
            w_cnt_nxt = 16'd0;
            if (req0_valid || req1_valid) begin
               w_grant     = 1'b1;
               w_issue     = 1'b1;
               w_state_nxt = ISSUE;
            end
         end
         // first ISSUE cycle sets up cfg_*, tx_en is high in the next two
         ISSUE: begin
            if (r_cnt == PHASE_LAST) begin
               w_cnt_nxt   = 16'd0;
               w_state_nxt = WAIT;
            end else begin
               w_tx_en_nxt = 1'b1;
            end
         end
         // a completion wins over a timeout expiring in the same cycle
         WAIT: begin
            if (cpl_rcv) begin
               w_cnt_nxt = 16'd0;
               if (w_crs_retry) begin
                  w_state_nxt = GAP;
               end else begin
                  w_cap       = 1'b1;
                  w_status    = cpl_status;
                  w_rdata     = r_cfg_fmt ? 32'd0 : cpl_rx_data;
                  w_state_nxt = DONE;
               end
            end else if (r_cnt == TIMEOUT_CYC - 16'd1) begin
               w_cnt_nxt   = 16'd0;
               w_cap       = 1'b1;
               w_timeout   = 1'b1;
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            w_cnt_nxt   = 16'd0;
            w_state_nxt = GAP;
         end
         GAP: begin
            if (r_cnt == PHASE_LAST) begin
               w_cnt_nxt = 16'd0;
               if (w_retry_pend) begin
                  w_issue     = 1'b1;
                  w_state_nxt = ISSUE;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_cnt_nxt   = 16'd0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, transaction fields and per-requester results
   always_ff @(posedge pclk_div2 or posedge apb_rst) begin
      if (apb_rst) begin
         r_state       <= IDLE;
         r_cnt         <= 16'd0;
         r_tx_en       <= 1'b0;
         r_gnt         <= 1'b0;
         r_rr_last     <= 1'b1;
         r_next_tag    <= TAG_BASE;
         r_cfg_tag     <= TAG_BASE;
         r_cfg_fmt     <= 1'b0;
         r_cfg_type    <= 1'b0;
         r_cfg_fbe     <= 4'd0;
         r_cfg_des_id  <= 16'd0;
         r_cfg_reg_num <= 10'd0;
         r_cfg_tx_data <= 32'd0;
         r_done0       <= 1'b0;
         r_done1       <= 1'b0;
         r_timeout0    <= 1'b0;
         r_timeout1    <= 1'b0;
         r_status0     <= 3'b000;
         r_status1     <= 3'b000;
         r_rdata0      <= 32'd0;
         r_rdata1      <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_tx_en <= w_tx_en_nxt;
         if (w_grant) begin
            r_gnt         <= w_gnt_id;
            if (req0_valid && req1_valid) r_rr_last <= w_gnt_id;
            r_cfg_fmt     <= w_gnt_id ? req1_wr      : req0_wr;
            r_cfg_type    <= w_gnt_id ? req1_type    : req0_type;
            r_cfg_fbe     <= w_gnt_id ? req1_fbe     : req0_fbe;
            r_cfg_des_id  <= w_gnt_id ? req1_des_id  : req0_des_id;
            r_cfg_reg_num <= w_gnt_id ? req1_reg_num : req0_reg_num;
            r_cfg_tx_data <= w_gnt_id ? req1_wdata   : req0_wdata;
         end
         if (w_issue) begin
            r_cfg_tag  <= r_next_tag;
            r_next_tag <= r_next_tag + 8'd1;
         end
         r_done0 <= w_cap && !r_gnt;
         r_done1 <= w_cap && r_gnt;
         if (w_cap && !r_gnt) begin
            r_status0  <= w_status;
            r_rdata0   <= w_rdata;
            r_timeout0 <= w_timeout;
         end
         if (w_cap && r_gnt) begin
            r_status1  <= w_status;
            r_rdata1   <= w_rdata;
            r_timeout1 <= w_timeout;
         end
      end
   end

   assign tx_en        = r_tx_en;
   assign cfg_fmt      = r_cfg_fmt;
   assign cfg_type     = r_cfg_type;
   assign cfg_tag      = r_cfg_tag;
   assign cfg_fbe      = r_cfg_fbe;
   assign cfg_des_id   = r_cfg_des_id;
   assign cfg_reg_num  = r_cfg_reg_num;
   assign cfg_tx_data  = r_cfg_tx_data;
   assign req0_done    = r_done0;
   assign req0_status  = r_status0;
   assign req0_rdata   = r_rdata0;
   assign req0_timeout = r_timeout0;
   assign req1_done    = r_done1;
   assign req1_status  = r_status1;
   assign req1_rdata   = r_rdata1;
   assign req1_timeout = r_timeout1;

endmodule

// File: doc/pcie_cfg_arb.md
PCIE_CFG_ARB -- requirements
Module: pcie_cfg_arb

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16'd50000, completion-wait limit in cycles.
REQ-002 Parameter TAG_BASE, default 8'h10, tag value after reset.
REQ-003 Parameter MAX_RETRY, default 4'd8, CRS reissue limit.
REQ-004 pclk_div2  in  1  sole clock; all logic rising-edge.
REQ-005 apb_rst  in  1  asynchronous, active-high reset.
REQ-006 reqN_valid  in  1  (N=0,1) request pending; held until reqN_done.
REQ-007 reqN_wr / reqN_type  in  1/1  write (1) or read (0); Type1 (1) or Type0 (0).
REQ-008 reqN_fbe, reqN_des_id, reqN_reg_num, reqN_wdata  in  4/16/10/32  TLP fields.
REQ-009 reqN_done  out  1  one-cycle completion pulse.
REQ-010 reqN_status, reqN_rdata, reqN_timeout  out  3/32/1  results, valid while reqN_done is high.
REQ-011 cfg_fmt, cfg_type, cfg_tag, cfg_fbe, cfg_des_id, cfg_reg_num, cfg_tx_data  out  1/1/8/4/16/10/32  fields to the configuration transactor.
REQ-012 tx_en  out  1  transactor launch level.
REQ-013 cpl_rcv, cpl_status, cpl_rx_data  in  1/3/32  completion from the transactor.

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT, DONE, GAP.
REQ-015 IDLE: any reqN_valid -> latch the granted requester's fields into cfg_* registers; go to ISSUE.
REQ-016 Arbitration round-robin: on simultaneous valid, the requester not granted last wins; after reset requester 0 wins.
REQ-017 ISSUE: tx_en high exactly 2 cycles, then -> WAIT with the timeout counter cleared.
REQ-018 cfg_* outputs stay stable from the ISSUE entry until the GAP exit.
REQ-019 cfg_tag increments by 1 at each ISSUE entry, 8'hFF wraps to 8'h00.
REQ-020 WAIT: cpl_rcv -> capture cpl_status; capture cpl_rx_data if read, else capture 0; -> DONE.
REQ-021 WAIT: counter reaching TIMEOUT_CYC-1 with no cpl_rcv -> timeout flag set, status 3'b000, rdata 0; -> DONE.
REQ-022 cpl_rcv on the same cycle as counter expiry counts as completion, not timeout.
REQ-023 DONE: the granted reqN_done pulses 1 cycle, carrying status, rdata and timeout; -> GAP.
REQ-024 GAP: tx_en low 3 cycles, so the transactor edge detector re-arms; cpl_rcv is ignored; -> IDLE.
REQ-025 cpl_rcv outside WAIT is discarded.
REQ-026 Ungranted reqN_done stays 0; ready-to-accept latency from valid to first tx_en cycle is 2 cycles.

Reset
REQ-027 apb_rst sets all of the following immediately, including mid-transaction:
- FSM to IDLE;
- tx_en, reqN_done and reqN_timeout to 0;
- reqN_status, reqN_rdata and all cfg_* except cfg_tag to 0;
- cfg_tag to TAG_BASE;
- round-robin pointer to favour requester 0;
- retry and timeout counters to 0.

Configuration
REQ-028 Macro CFG_CRS_RETRY_EN defined: in WAIT, cpl_status 3'b010 (CRS) with retry count < MAX_RETRY increments the retry count and goes to GAP, then ISSUE with a new tag, without pulsing done.
REQ-029 With CFG_CRS_RETRY_EN defined, a CRS at the retry limit completes normally with status 3'b010; the retry count clears on each new grant.
REQ-030 Macro CFG_CRS_RETRY_EN undefined: CRS is treated as any other completion status; no retry counter is present.

Verification
REQ-031 req0 read, des_id 16'h0100, reg_num 10'h000; cpl_rcv status 0, data 32'h10EE_1234 after 5 cycles -> tx_en high 2 cycles, cfg_tag 8'h10, req0_done with rdata 32'h10EE_1234.
REQ-032 req0 and req1 valid in the same cycle after reset -> req0 served (tag 8'h10), then req1 (tag 8'h11).
REQ-033 A second simultaneous round -> req1 served first, then req0.
REQ-034 req1 write, wdata 32'hDEAD_BEEF; no completion; TIMEOUT_CYC=100 -> req1_done 100 cycles after WAIT entry with timeout 1, rdata 0; a late cpl_rcv in GAP has no effect.
REQ-035 CFG_CRS_RETRY_EN defined, MAX_RETRY=2; three CRS completions -> tags 8'h10, 8'h11, 8'h12 issued, single done with status 3'b010.
REQ-036 apb_rst asserted during WAIT -> tx_en 0, no done pulse, cfg_tag 8'h10; the next request is issued normally.
